i2c_target_regif: RTL
=====================

Name: i2c_target_regif

Overview:
- I2C/SCCB target (responder) that sits at the far end of the bus from the team's ROM-driven command master.
- Oversamples SCL/SDA in the system clock domain and decodes START, STOP and repeated START.
- Matches a 7-bit device address, takes an 8-bit register pointer, then turns write bytes into register-write strobes and serves read bytes from an external register port.
- Used as an on-chip camera model in benches and as a loopback target for the configuration path.

Parameters:
p_slave_addr, 'h21, 7-bit device address this target answers to
p_ack_enable, 1'b1, 1: drive ACK low on matched bytes; 0: SCCB don't-care, ACK slot left released
p_filter_len, 3, consecutive equal samples required to accept a new SCL/SDA level (glitch filter)

Ports:
i_clk  in  1  system clock; bus sampled on rising edge
i_rst  in  1  asynchronous, active-high reset
i_scl  in  1  bus SCL (raw, asynchronous)
i_sda  in  1  bus SDA (raw, asynchronous)
o_sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
o_wr_valid  out  1  one-cycle strobe, register write
o_wr_addr  out  8  register address for write
o_wr_data  out  8  register data for write
o_rd_req  out  1  one-cycle strobe requesting o_rd_addr
o_rd_addr  out  8  register address for read
i_rd_data  in  8  read data, valid exactly 1 cycle after o_rd_req
o_busy  out  1  high from START to STOP
o_addr_match  out  1  high from matched address ACK until STOP/START

Behaviour:
- Reset (async, any state): all outputs 0, pointer 0x00, state IDLE; SDA released immediately.
- Input path: 2-FF synchronizer, then filter (level changes after p_filter_len equal samples), then rise/fall detect on the filtered signals.
- START: SDA fall while SCL high. Valid in any state; aborts the current byte and enters DEV_ADDR (repeated START included). Bit counter cleared; pointer kept.
- STOP: SDA rise while SCL high. Goes to IDLE from any state and releases SDA.
- Bits are sampled on the SCL rise edge, MSB first. o_sda_oe changes only on the cycle after an SCL fall edge.
- States and transitions:
  - IDLE: waits for START.
  - DEV_ADDR: shifts 8 bits. On match go to ACK_DEV; on mismatch go to IGNORE, which holds SDA released until STOP/START.
  - ACK_DEV: drives ACK (if p_ack_enable) for the 9th clock. R/W=0 goes to REG_ADDR. R/W=1 pulses o_rd_req with o_rd_addr=pointer on the SCL fall ending the ACK, captures i_rd_data next cycle, then goes to RD_DATA.
  - REG_ADDR: 8 bits loaded into the pointer, then ACK_REG, then WR_DATA.
  - WR_DATA: 8 bits. At the 8th SCL rise, pulse o_wr_valid for 1 cycle with addr=pointer. Go to ACK_WR; pointer increments.
  - ACK_WR: returns to WR_DATA.
  - RD_DATA: drives bit values (oe = ~bit), then releases SDA for the master ACK slot and samples it.
    - ACK (0): pointer increments, o_rd_req pulses again, reload, stay in RD_DATA.
    - NACK (1): go to IGNORE.
- Pointer arithmetic: 8-bit and wraps 0xFF→0x00 on both write and read.
- Simultaneous START and STOP detect in one cycle is impossible (single SDA edge), so no arbitration is needed.
- Reset mid-byte: no partial write strobe is emitted.

Decomposition:
- i2c_pkg: t_i2c_target_state enum (IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE); constants for ACK=0 and NACK=1.
- One sub-module, i2c_bus_sync: synchronizer, glitch filter and edge/START/STOP detect for SCL/SDA; instantiated once.

Test Plan:
- Write cycle: START, 0x42 ACK, 0x12 ACK, 0x80 ACK, STOP → single o_wr_valid with addr 0x12, data 0x80; o_sda_oe high in all three ACK slots.
- Address mismatch: START, 0x60 (addr 0x30) → no ACK, no strobes, o_sda_oe stays 0 until STOP.
- Burst write with wrap: reg 0xFE, data 0x11, 0x22, 0x33 → writes (0xFE,0x11), (0xFF,0x22), (0x00,0x33).
- Read: write reg 0x0A, repeated START, 0x43, bench returns 0x76 then 0x77, master ACK then NACK → SDA shows 0x76 then 0x77; o_rd_addr 0x0A then 0x0B; SDA released after NACK.
- SCCB mode with p_ack_enable=0 → same write strobes as the write-cycle test; o_sda_oe never asserted.
- Reset asserted mid WR_DATA (bit 4) → outputs 0 asynchronously, no o_wr_valid; a subsequent full write succeeds.

Source files
------------

// File: rtl/i2c_target_regif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_regif_pkg
// Description : Shared types and constants for the I2C/SCCB register target.
//               Holds the target state encoding and the ACK/NACK bus levels.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_target_regif_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEV_ADDR = 4'd1,
    ST_ACK_DEV  = 4'd2,
    ST_REG_ADDR = 4'd3,
    ST_ACK_REG  = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_ACK_WR   = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } t_i2c_target_state;

  // SDA level seen in an acknowledge slot.
  localparam logic c_ack  = 1'b0;
  localparam logic c_nack = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_target_regif_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_regif_if
// Description : Bus and register-port bundle of the I2C register target.
//               slave modport  : seen by the target (i2c_target_regif)
//               master modport : seen by whatever drives the bus / serves reads
// Signals     : i_scl, i_sda      raw bus lines
//               o_sda_oe          1 = target pulls SDA low
//               o_wr_valid/addr/data  register write strobe
//               o_rd_req/addr, i_rd_data  register read port (data 1 cycle later)
//               o_busy, o_addr_match  status
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_target_regif_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda_oe;
  logic       o_wr_valid;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_rd_req;
  logic [7:0] o_rd_addr;
  logic [7:0] i_rd_data;
  logic       o_busy;
  logic       o_addr_match;

  modport slave (
    input  i_scl, i_sda, i_rd_data,
    output o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data,
           o_rd_req, o_rd_addr, o_busy, o_addr_match
  );

  modport master (
    output i_scl, i_sda, i_rd_data,
    input  o_sda_oe, o_wr_valid, o_wr_addr, o_wr_data,
           o_rd_req, o_rd_addr, o_busy, o_addr_match
  );
endinterface
`default_nettype wire

// File: rtl/i2c_target_regif_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_regif_bus_sync
// Description : SCL/SDA front end: 2-FF synchronizer, glitch filter and
//               edge / START / STOP detection in the system clock domain.
// Ports       : i_clk, i_rst        clock, async active-high reset
//               i_scl, i_sda        raw bus lines
//               o_sda               filtered SDA level
//               o_scl_rise/o_scl_fall  one-cycle filtered SCL edges
//               o_start/o_stop      one-cycle bus condition pulses
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regif_bus_sync #(
  parameter int p_filter_len = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  localparam int c_cnt_w = (p_filter_len > 1) ? $clog2(p_filter_len) : 1;

  logic [1:0] w_raw;   // [0] = SCL, [1] = SDA
  logic [1:0] w_filt;
  logic [1:0] w_filt_q;

  assign w_raw = {i_sda, i_scl};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic               r_meta;
    logic               r_sync;
    logic               r_filt;
    logic               r_filt_q;
    logic [c_cnt_w-1:0] r_cnt;

    // Idle bus is high, so everything resets to 1 to avoid false edges.
    // The filtered level only moves after p_filter_len consecutive samples
    // that disagree with it; any sample agreeing again restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_meta   <= 1'b1;
        r_sync   <= 1'b1;
        r_filt   <= 1'b1;
        r_filt_q <= 1'b1;
        r_cnt    <= '0;
      end else begin
        r_meta   <= w_raw[g];
        r_sync   <= r_meta;
        r_filt_q <= r_filt;
        if (r_sync == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_w'(p_filter_len - 1)) begin
          r_filt <= r_sync;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_filt[g]   = r_filt;
    assign w_filt_q[g] = r_filt_q;
  end

  assign o_sda      = w_filt[1];
  assign o_scl_rise =  w_filt[0] & ~w_filt_q[0];
  assign o_scl_fall = ~w_filt[0] &  w_filt_q[0];
  // SDA edges only count as bus conditions when SCL was high on both samples.
  assign o_start    = w_filt[0] & w_filt_q[0] &  w_filt_q[1] & ~w_filt[1];
  assign o_stop     = w_filt[0] & w_filt_q[0] & ~w_filt_q[1] &  w_filt[1];

endmodule
`default_nettype wire

// File: rtl/i2c_target_regif.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_regif
// Description : I2C/SCCB target with 8-bit register pointer. Write bytes
//               become register-write strobes, read bytes are fetched from an
//               external register port. Usable as a camera model / loopback.
// Ports       : i_clk, i_rst   system clock, async active-high reset
//               bus            i2c_target_regif_if.slave (bus lines,
//                              register write/read port, status)
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regif #(
  parameter logic [6:0] p_slave_addr = 7'h21,
  parameter bit         p_ack_enable = 1'b1,
  parameter int         p_filter_len = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  i2c_target_regif_if.slave     bus
);
  import i2c_target_regif_pkg::*;

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_target_regif_bus_sync #(
    .p_filter_len (p_filter_len)
  ) u_bus_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (bus.i_scl),
    .i_sda      (bus.i_sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  t_i2c_target_state r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;     // 7 bits suffice: the 8th bit is always w_sda / rd_data[7]
  logic [7:0] r_ptr;
  logic       r_rw;
  logic       r_ack_seen;  // ACK slot: its SCL rise has passed
  logic       r_rd_wait;   // i_rd_data is valid this cycle
  logic       r_sda_oe;
  logic       r_wr_valid;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_rd_req;
  logic [7:0] r_rd_addr;
  logic       r_busy;
  logic       r_addr_match;

  logic [7:0] w_byte;
  logic       w_last_bit;

  assign w_byte     = {r_shift, w_sda};
  assign w_last_bit = (r_bit_cnt == 3'd7);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_ptr        <= '0;
      r_rw         <= 1'b0;
      r_ack_seen   <= 1'b0;
      r_rd_wait    <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_busy       <= 1'b0;
      r_addr_match <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_wait  <= r_rd_req;

      if (w_start) begin
        // Repeated START lands here too; the pointer is deliberately kept.
        r_state      <= ST_DEV_ADDR;
        r_bit_cnt    <= '0;
        r_sda_oe     <= 1'b0;
        r_busy       <= 1'b1;
        r_addr_match <= 1'b0;
        r_rd_wait    <= 1'b0;
      end else if (w_stop) begin
        r_state      <= ST_IDLE;
        r_bit_cnt    <= '0;
        r_sda_oe     <= 1'b0;
        r_busy       <= 1'b0;
        r_addr_match <= 1'b0;
        r_rd_wait    <= 1'b0;
      end else begin
        // Read data arrives while SCL is still low: present its MSB now.
        if (r_rd_wait && (r_state == ST_RD_DATA)) begin
          r_shift  <= bus.i_rd_data[6:0];
          r_sda_oe <= ~bus.i_rd_data[7];
        end

        case (r_state)
          ST_DEV_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                if (w_byte[7:1] == p_slave_addr) begin
                  r_state      <= ST_ACK_DEV;
                  r_rw         <= w_byte[0];
                  r_addr_match <= 1'b1;
                  r_ack_seen   <= 1'b0;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
            end
          end

          ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: begin
            if (w_scl_rise) r_ack_seen <= 1'b1;
            if (w_scl_fall) begin
              if (!r_ack_seen) begin
                // Fall that ends the 8th bit opens the ACK slot.
                r_sda_oe <= p_ack_enable;
              end else begin
                // Fall that ends the ACK slot.
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
                if (r_state == ST_ACK_DEV) begin
                  if (r_rw) begin
                    r_rd_req  <= 1'b1;
                    r_rd_addr <= r_ptr;
                    r_state   <= ST_RD_DATA;
                  end else begin
                    r_state <= ST_REG_ADDR;
                  end
                end else begin
                  r_state <= ST_WR_DATA;
                end
              end
            end
          end

          ST_REG_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_ptr      <= w_byte;
                r_state    <= ST_ACK_REG;
                r_ack_seen <= 1'b0;
              end
            end
          end

          ST_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_ptr;
                r_wr_data  <= w_byte;
                r_ptr      <= r_ptr + 8'd1;
                r_state    <= ST_ACK_WR;
                r_ack_seen <= 1'b0;
              end
            end
          end

          ST_RD_DATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_state    <= ST_RD_ACK;
                r_ack_seen <= 1'b0;
              end
            end
            if (w_scl_fall) begin
              r_shift  <= {r_shift[5:0], 1'b0};
              r_sda_oe <= ~r_shift[6];
            end
          end

          ST_RD_ACK: begin
            if (w_scl_rise) begin
              if (w_sda == c_nack) r_state <= ST_IGNORE;
              else                 r_ack_seen <= 1'b1;
            end
            if (w_scl_fall) begin
              if (r_ack_seen) begin
                r_ptr     <= r_ptr + 8'd1;
                r_rd_req  <= 1'b1;
                r_rd_addr <= r_ptr + 8'd1;
                r_bit_cnt <= '0;
                r_state   <= ST_RD_DATA;
              end else begin
                // Release SDA for the master's ACK/NACK.
                r_sda_oe <= 1'b0;
              end
            end
          end

          ST_IDLE, ST_IGNORE: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_sda_oe     = r_sda_oe;
  assign bus.o_wr_valid   = r_wr_valid;
  assign bus.o_wr_addr    = r_wr_addr;
  assign bus.o_wr_data    = r_wr_data;
  assign bus.o_rd_req     = r_rd_req;
  assign bus.o_rd_addr    = r_rd_addr;
  assign bus.o_busy       = r_busy;
  assign bus.o_addr_match = r_addr_match;

endmodule
`default_nettype wire
